// File: rtl/mips_core_pkg.sv
// mips_core_pkg: shared widths and CDB source encoding for the core.
package mips_core_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ROB_DEPTH_BITS = 5;
  typedef enum logic {CDB_SRC_ALU, CDB_SRC_DCACHE} CdbSrc;
endpackage

// File: rtl/cdb_result_fifo.sv
// cdb_result_fifo: per-source result queue feeding the CDB arbiter.
module cdb_result_fifo
  import mips_core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_flush,
  input  logic                            i_push,
  input  logic                            i_pop,
  input  logic [ROB_DEPTH_BITS-1:0]       i_tag,
  input  logic [DATA_WIDTH-1:0]           i_data,
  output logic [ROB_DEPTH_BITS-1:0]       o_tag,
  output logic [DATA_WIDTH-1:0]           o_data,
  output logic                            o_empty,
  output logic [$clog2(DEPTH):0]          o_count,
  output logic                            o_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  logic [AW-1:0]               r_head, r_tail;
  logic [AW:0]                 r_count;
  logic [ROB_DEPTH_BITS-1:0]   r_tag [DEPTH];
  logic [DATA_WIDTH-1:0]       r_data [DEPTH];
  logic                        w_full, w_pop, w_push;
  assign w_full  = r_count == CNT_FULL;
  assign o_empty = r_count == '0;
  assign w_pop   = i_pop & ~o_empty & ~i_flush;
  // a pop frees the slot in the same cycle, so a full queue can still accept
  assign w_push  = i_push & ~i_flush & (~w_full | w_pop);
  assign o_drop  = i_push & ~i_flush & w_full & ~w_pop;
  assign o_tag   = r_tag[r_head];
  assign o_data  = r_data[r_head];
  assign o_count = r_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_pop);
      r_tail  <= r_tail + AW'(w_push);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag[r_tail]  <= i_tag;
      r_data[r_tail] <= i_data;
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin merge of ALU and load results onto the common data bus.
module cdb_arbiter
  import mips_core_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      alu_valid,
  input  logic [ROB_DEPTH_BITS-1:0] alu_tag,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic                      dc_valid,
  input  logic [ROB_DEPTH_BITS-1:0] dc_tag,
  input  logic [DATA_WIDTH-1:0]     dc_data,
  output logic                      cdb_valid,
  output logic [ROB_DEPTH_BITS-1:0] cdb_tag,
  output logic [DATA_WIDTH-1:0]     cdb_data,
  output logic                      alu_stall,
  output logic                      dc_stall,
  output logic                      overflow_err
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam logic [AW:0] STALL_AT = (AW+1)'(QUEUE_DEPTH-1);
  CdbSrc                     r_last_grant;
  logic                      r_overflow;
  logic [ROB_DEPTH_BITS-1:0] w_alu_tag, w_dc_tag;
  logic [DATA_WIDTH-1:0]     w_alu_data, w_dc_data;
  logic                      w_alu_empty, w_dc_empty, w_alu_drop, w_dc_drop;
  logic [AW:0]               w_alu_count, w_dc_count;
  logic                      w_grant_alu, w_grant_dc;
  cdb_result_fifo #(.DEPTH(QUEUE_DEPTH)) u_alu_q (
    .clk(clk), .rst(rst), .i_flush(flush), .i_push(alu_valid), .i_pop(w_grant_alu),
    .i_tag(alu_tag), .i_data(alu_result), .o_tag(w_alu_tag), .o_data(w_alu_data),
    .o_empty(w_alu_empty), .o_count(w_alu_count), .o_drop(w_alu_drop)
  );
  cdb_result_fifo #(.DEPTH(QUEUE_DEPTH)) u_dc_q (
    .clk(clk), .rst(rst), .i_flush(flush), .i_push(dc_valid), .i_pop(w_grant_dc),
    .i_tag(dc_tag), .i_data(dc_data), .o_tag(w_dc_tag), .o_data(w_dc_data),
    .o_empty(w_dc_empty), .o_count(w_dc_count), .o_drop(w_dc_drop)
  );
  // on a tie the source that did not win last time gets the bus
  assign w_grant_alu  = ~w_alu_empty & (w_dc_empty | r_last_grant == CDB_SRC_DCACHE);
  assign w_grant_dc   = ~w_dc_empty & ~w_grant_alu;
  assign cdb_valid    = w_grant_alu | w_grant_dc;
  assign cdb_tag      = w_grant_alu ? w_alu_tag : w_grant_dc ? w_dc_tag : '0;
  assign cdb_data     = w_grant_alu ? w_alu_data : w_grant_dc ? w_dc_data : '0;
  assign alu_stall    = w_alu_count >= STALL_AT;
  assign dc_stall     = w_dc_count >= STALL_AT;
  assign overflow_err = r_overflow;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= CDB_SRC_DCACHE;
      r_overflow   <= 1'b0;
    end else begin
      r_overflow   <= r_overflow | w_alu_drop | w_dc_drop;
      r_last_grant <= flush ? CDB_SRC_DCACHE : w_grant_alu ? CDB_SRC_ALU :
                      w_grant_dc ? CDB_SRC_DCACHE : r_last_grant;
    end
  end
endmodule
